voter_tally: RTL and testbench
==============================

Name: voter_tally

Overview:
- Parametrised, clocked successor to the combinational 4-input voter.
- Runs a voting session for N_VOTERS voters:
  - opens a ballot;
  - accepts at most one vote per voter;
  - counts yes/no votes;
  - on close, latches a one-hot pass/tie/fail verdict.
- Sits between voter push-button/switch inputs and the result display logic.

Parameters:
- N_VOTERS, 4: number of voter channels, minimum 2.
- CNT_W, $clog2(N_VOTERS+1): width of the yes/no counters.
- TIMEOUT_CYC, 16: OPEN-state cycle limit, used only when VOTE_TIMEOUT_EN is defined; minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- open_i  input  1  single-cycle pulse; starts a new session.
- close_i  input  1  single-cycle pulse; ends the current session.
- vote_en  input  N_VOTERS  bit i high = voter i casts a vote this cycle.
- vote_yes  input  N_VOTERS  bit i = value of voter i's vote (1 yes, 0 no); sampled only with vote_en[i].
- voted  output  N_VOTERS  registered mask of voters already counted this session.
- yes_cnt  output  CNT_W  registered yes count.
- no_cnt  output  CNT_W  registered no count.
- busy  output  1  high in OPEN.
- done  output  1  high in DONE.
- O  output  3 ([3:1])  registered verdict: O[3] pass, O[2] tie, O[1] fail; one-hot in DONE, 3'b000 otherwise.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous, active-low (rst_n).
  - Reset values: state IDLE; voted, yes_cnt, no_cnt, O = 0; busy = 0; done = 0.
  - Reset asserted mid-session discards the session immediately. No verdict is produced.
- States: IDLE, OPEN, DONE.
- IDLE:
  - open_i → OPEN next cycle. On that transition, voted, yes_cnt, no_cnt and O are cleared.
  - close_i and vote_en are ignored.
  - open_i and close_i together in IDLE: open wins; close is ignored.
- OPEN:
  - busy = 1.
  - Each cycle, voter i is accepted iff vote_en[i] && !voted[i].
  - On acceptance, set voted[i] and increment yes_cnt if vote_yes[i], else no_cnt.
  - Any number of voters may be accepted in the same cycle. Counters add the popcount of accepted yes votes and of accepted no votes.
  - Repeat votes (voted[i] already set) are ignored. A voter cannot change a vote.
  - open_i is ignored in OPEN.
- OPEN → DONE when either:
  - close_i = 1; or
  - every bit of the post-update voted mask is 1 (all voters have voted).
- Votes presented in the close cycle are counted before the verdict is formed.
- Verdict:
  - Computed from the post-update counts.
  - Registered on the transition edge, so O is valid in the first DONE cycle. Latency is 1 clock from the last vote or close_i.
  - Rules: yes > no → 3'b100; yes == no (including 0/0) → 3'b010; yes < no → 3'b001.
  - Abstentions are not counted.
- DONE:
  - done = 1; O, counts and voted are held.
  - close_i and vote_en are ignored.
  - open_i → OPEN with the same clear as from IDLE. O returns to 3'b000 in the new session.
- Counters cannot overflow: maximum value is N_VOTERS, which CNT_W covers.

Optional Feature:
- Macro: VOTE_TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on entry to OPEN and increments each OPEN cycle.
  - When it reaches TIMEOUT_CYC-1 without another close condition, the FSM goes to DONE on the next edge, exactly as if close_i had been asserted.
  - Votes in that final cycle are counted.
- Undefined:
  - No counter is present.
  - OPEN lasts until close_i or all voters have voted.

Test Plan (N_VOTERS=4):
- Reset, then open; voters 0, 1, 2 vote yes in one cycle; voter 3 votes no next cycle → auto-close; yes_cnt=3, no_cnt=1, O=3'b100, done=1 one cycle after voter 3.
- Open; voter 0 yes, voter 1 no; close_i → O=3'b010 (tie), voted=4'b0011.
- Open; voter 2 no; voter 2 votes yes twice more; close → no_cnt=1, yes_cnt=0, O=3'b001 (repeat votes ignored).
- Open; close_i in the same cycle as vote_en=4'b1111 with vote_yes=4'b0011 → counts 2/2, O=3'b010.
- Open; two votes; assert rst_n=0 mid-session → all outputs 0 immediately; after release, state IDLE; close_i ignored.
- With VOTE_TIMEOUT_EN: open, no votes → done rises after TIMEOUT_CYC cycles, O=3'b010. Without the macro: busy stays high indefinitely.

Source files
------------

// File: rtl/voter_tally.sv
// Clocked voting-session tally: opens a ballot, counts one vote per voter, latches a one-hot verdict.
// Optional macro VOTE_TIMEOUT_EN adds an OPEN-state cycle limit of TIMEOUT_CYC.
module voter_tally #(
    parameter int unsigned N_VOTERS    = 4,
    parameter int unsigned CNT_W       = $clog2(N_VOTERS + 1),
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                open_i,
    input  logic                close_i,
    input  logic [N_VOTERS-1:0] vote_en,
    input  logic [N_VOTERS-1:0] vote_yes,
    output logic [N_VOTERS-1:0] voted,
    output logic [CNT_W-1:0]    yes_cnt,
    output logic [CNT_W-1:0]    no_cnt,
    output logic                busy,
    output logic                done,
    output logic [3:1]          O
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OPEN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (N_VOTERS < 2 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("voter_tally: N_VOTERS and TIMEOUT_CYC must be at least 2");
    end

    logic [1:0]          state_q, state_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [CNT_W-1:0]    yes_q, yes_d;
    logic [CNT_W-1:0]    no_q, no_d;
    logic [3:1]          o_q, o_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N_VOTERS-1:0] accept;
    logic [CNT_W-1:0]    yes_add, no_add;
    logic                tmo_hit;

`ifdef VOTE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // First-time votes this cycle, split into yes/no popcounts
    always_comb begin
        accept  = vote_en & ~voted_q;
        yes_add = '0;
        no_add  = '0;
        for (int i = 0; i < int'(N_VOTERS); i++) begin
            if (accept[i]) begin
                if (vote_yes[i]) yes_add = yes_add + CNT_W'(1);
                else             no_add  = no_add + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        voted_d = voted_q;
        yes_d   = yes_q;
        no_d    = no_q;
        o_d     = o_q;
`ifdef VOTE_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (open_i) begin
                    state_d = S_OPEN;
                    voted_d = '0;
                    yes_d   = '0;
                    no_d    = '0;
                    o_d     = 3'b000;
`ifdef VOTE_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_OPEN: begin
                voted_d = voted_q | accept;
                yes_d   = yes_q + yes_add;
                no_d    = no_q + no_add;
                // Verdict uses the counts including this cycle's votes
                if (close_i || (&voted_d) || tmo_hit) begin
                    state_d = S_DONE;
                    if (yes_d > no_d)       o_d = 3'b100;
                    else if (yes_d == no_d) o_d = 3'b010;
                    else                    o_d = 3'b001;
                end
`ifdef VOTE_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_OPEN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            voted_q <= '0;
            yes_q   <= '0;
            no_q    <= '0;
            o_q     <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            voted_q <= voted_d;
            yes_q   <= yes_d;
            no_q    <= no_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef VOTE_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign voted   = voted_q;
    assign yes_cnt = yes_q;
    assign no_cnt  = no_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign O       = o_q;

endmodule

// File: tb/tb_voter_tally.sv
// Randomized bench for voter_tally against a session-level reference model; directed cases first.
module tb_voter_tally;

    localparam int N   = 4;
    localparam int CW  = 3;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         open_i, close_i;
    logic [N-1:0] vote_en, vote_yes;
    logic [N-1:0] voted;
    logic [CW-1:0] yes_cnt, no_cnt;
    logic         busy, done;
    logic [3:1]   O;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: session phase, per-voter ballot box, totals, verdict
    typedef enum int {M_IDLE, M_OPEN, M_DONE} mphase_t;
    mphase_t m_phase;
    bit      m_voted [N];
    int      m_yes, m_no, m_open_cycles, m_verdict;

    voter_tally #(.N_VOTERS(N), .CNT_W(CW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .open_i(open_i), .close_i(close_i),
        .vote_en(vote_en), .vote_yes(vote_yes), .voted(voted),
        .yes_cnt(yes_cnt), .no_cnt(no_cnt), .busy(busy), .done(done), .O(O)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = M_IDLE;
        foreach (m_voted[i]) m_voted[i] = 1'b0;
        m_yes = 0; m_no = 0; m_open_cycles = 0; m_verdict = 0;
    endfunction

    function automatic void model_step(input bit op, input bit cl, input bit [N-1:0] en, input bit [N-1:0] y);
        bit all_in;
        bit timed_out;
        if (m_phase == M_OPEN) begin
            for (int i = 0; i < N; i++)
                if (en[i] && !m_voted[i]) begin
                    m_voted[i] = 1'b1;
                    if (y[i]) m_yes++; else m_no++;
                end
            all_in = 1'b1;
            foreach (m_voted[i]) if (!m_voted[i]) all_in = 1'b0;
            m_open_cycles++;
`ifdef VOTE_TIMEOUT_EN
            timed_out = (m_open_cycles >= TMO);
`else
            timed_out = 1'b0;
`endif
            if (cl || all_in || timed_out) begin
                m_phase   = M_DONE;
                m_verdict = (m_yes > m_no) ? 4 : (m_yes == m_no) ? 2 : 1;
            end
        end else if (op) begin
            model_reset();
            m_phase = M_OPEN;
        end
    endfunction

    task automatic compare_all();
        int mask = 0;
        for (int i = 0; i < N; i++) if (m_voted[i]) mask |= (1 << i);
        check_eq("voted",   int'(voted),   mask);
        check_eq("yes_cnt", int'(yes_cnt), m_yes);
        check_eq("no_cnt",  int'(no_cnt),  m_no);
        check_eq("busy",    int'(busy),    int'(m_phase == M_OPEN));
        check_eq("done",    int'(done),    int'(m_phase == M_DONE));
        check_eq("O",       int'(O),       m_verdict);
    endtask

    // Apply one cycle of inputs, advance the model on the same edge, then compare
    task automatic cycle(input bit op, input bit cl, input bit [N-1:0] en, input bit [N-1:0] y);
        open_i = op; close_i = cl; vote_en = en; vote_yes = y;
        @(posedge clk);
        model_step(op, cl, en, y);
        #1;
        open_i = 1'b0; close_i = 1'b0; vote_en = '0; vote_yes = '0;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; open_i = 1'b0; close_i = 1'b0; vote_en = '0; vote_yes = '0;
        model_reset();
        #2;
        compare_all();
        #10 rst_n = 1'b1;

        // Three yes in one cycle, last voter no, auto-close
        cycle(1, 0, 4'b0000, 4'b0000);
        cycle(0, 0, 4'b0111, 4'b0111);
        cycle(0, 0, 4'b1000, 4'b0000);
        check_eq("t1_O", int'(O), 4);
        check_eq("t1_yes", int'(yes_cnt), 3);
        check_eq("t1_done", int'(done), 1);

        // Tie on close
        cycle(1, 0, 4'b0000, 4'b0000);
        cycle(0, 0, 4'b0011, 4'b0001);
        cycle(0, 1, 4'b0000, 4'b0000);
        check_eq("t2_O", int'(O), 2);
        check_eq("t2_voted", int'(voted), 3);

        // Repeat votes ignored
        cycle(1, 0, 4'b0000, 4'b0000);
        cycle(0, 0, 4'b0100, 4'b0000);
        cycle(0, 0, 4'b0100, 4'b0100);
        cycle(0, 0, 4'b0100, 4'b0100);
        cycle(0, 1, 4'b0000, 4'b0000);
        check_eq("t3_O", int'(O), 1);
        check_eq("t3_no", int'(no_cnt), 1);

        // Votes in the close cycle are counted
        cycle(1, 0, 4'b0000, 4'b0000);
        cycle(0, 1, 4'b1111, 4'b0011);
        check_eq("t4_O", int'(O), 2);
        check_eq("t4_yes", int'(yes_cnt), 2);

        // Open and close together in DONE: open wins, O cleared
        cycle(1, 1, 4'b0000, 4'b0000);
        check_eq("t5_O", int'(O), 0);

        // Async reset mid-session
        cycle(0, 0, 4'b0011, 4'b0010);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #2 rst_n = 1'b1;
        cycle(0, 1, 4'b0000, 4'b0000);
        check_eq("t6_busy", int'(busy), 0);

        // Idle-open session with no votes: timeout or stays open
        cycle(1, 0, 4'b0000, 4'b0000);
        for (int k = 0; k < TMO + 4; k++) cycle(0, 0, 4'b0000, 4'b0000);
`ifdef VOTE_TIMEOUT_EN
        check_eq("t7_done", int'(done), 1);
        check_eq("t7_O", int'(O), 2);
`else
        check_eq("t7_busy", int'(busy), 1);
`endif
        cycle(0, 1, 4'b0000, 4'b0000);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            bit op, cl;
            bit [N-1:0] en, y;
            op = ($urandom_range(7) == 0);
            cl = ($urandom_range(11) == 0);
            en = ($urandom_range(2) == 0) ? N'($urandom_range(15)) : '0;
            y  = N'($urandom_range(15));
            cycle(op, cl, en, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
